// File: rtl/nios2_ram_pkg.sv
// Shared master identifiers and default geometry for the on-chip RAM arbiter.
package nios2_ram_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam int unsigned DEF_ADDR_W = 15;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 20480;

endpackage

// File: rtl/nios2_rr_arb2.sv
// Two-request round-robin arbiter; grant is combinational, history is registered.
module nios2_rr_arb2
  import nios2_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output master_t    gnt_id
);

  master_t last_grant;

  // Sole requester wins; on a tie the master not granted last time wins.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = M0;
    unique case (req)
      2'b01:   gnt_id = M0;
      2'b10:   gnt_id = M1;
      2'b11:   gnt_id = (last_grant == M0) ? M1 : M0;
      default: gnt_id = M0;
    endcase
  end

  // History starts at M1 so that M0 wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant <= M1;
    else if (gnt_valid)
      last_grant <= gnt_id;
  end

endmodule

// File: rtl/nios2_ram_arbiter.sv
// Two Avalon-MM masters sharing one single-port on-chip RAM, one access per cycle.
module nios2_ram_arbiter
  import nios2_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic [1:0]          req;
  logic                gnt_valid;
  master_t             gnt_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W/8-1:0] sel_be;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic                sel_read;
  logic                sel_inrange;
  logic                acc_read;
  logic                rd_pend;
  logic                rd_oor;
  master_t             rd_owner;
  logic [DATA_W-1:0]   ret_data;

  // Requests are masked while in reset so nothing can be granted or accepted.
  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

  nios2_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the granted master's request fields.
  always_comb begin
    sel_addr  = m0_address;
    sel_be    = m0_byteenable;
    sel_wdata = m0_writedata;
    sel_write = m0_write;
    sel_read  = m0_read;
    if (gnt_id == M1) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_write = m1_write;
      sel_read  = m1_read;
    end
    sel_inrange = (32'(sel_addr) < DEPTH);
    acc_read    = gnt_valid && !sel_write && sel_read;
  end

  // Stall losers, never stall idle masters; everyone waits while in reset.
  always_comb begin
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (reset_n) begin
      m0_waitrequest = req[0] && !(gnt_valid && gnt_id == M0);
      m1_waitrequest = req[1] && !(gnt_valid && gnt_id == M1);
    end
  end

  // RAM drive; out-of-range accesses are accepted but never reach the RAM.
  always_comb begin
    ram_clken      = reset_n;
    ram_address    = sel_addr;
    ram_byteenable = sel_be;
    ram_writedata  = sel_wdata;
    ram_chipselect = gnt_valid && sel_inrange;
    ram_write      = gnt_valid && sel_inrange && sel_write;
  end

  // Remember who owns the read now in the RAM pipeline and whether it was real.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      rd_oor   <= 1'b0;
      rd_owner <= M0;
    end else begin
      rd_pend <= acc_read;
      if (acc_read) begin
        rd_owner <= gnt_id;
        rd_oor   <= !sel_inrange;
      end
    end
  end

  // Return data to the owner only; zero everywhere else.
  always_comb begin
    m0_readdatavalid = rd_pend && (rd_owner == M0);
    m1_readdatavalid = rd_pend && (rd_owner == M1);
    ret_data         = rd_oor ? '0 : ram_readdata;
    m0_readdata      = m0_readdatavalid ? ret_data : '0;
    m1_readdata      = m1_readdatavalid ? ret_data : '0;
  end

endmodule

// File: tb/tb_nios2_ram_arbiter.sv
// Self-checking bench for nios2_ram_arbiter with a behavioural RAM and reference model.
module tb_nios2_ram_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 20480;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios2_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  // Power-up contents of every RAM word, shared by the slave and the model.
  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM slave: registered q, read-during-write returns old data.
  logic [31:0] smem [DEPTH];
  bit          swr  [DEPTH];
  int unsigned ram_wr_count = 0;

  function automatic logic [31:0] slave_rd(input int unsigned a);
    return swr[a] ? smem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect && int'(ram_address) < DEPTH) begin
      ram_readdata <= slave_rd(ram_address);
      if (ram_write) begin
        smem[ram_address] <= merge(slave_rd(ram_address), ram_writedata, ram_byteenable);
        swr[ram_address]  <= 1'b1;
        ram_wr_count      <= ram_wr_count + 1;
      end
    end
  end

  // Reference model: transaction-level view of the arbiter's rules.
  logic [31:0] ref_mem [int];
  int          ref_last;
  bit          ex_pend;
  int          ex_owner;
  logic [31:0] ex_data;

  bit            e_gv, e_w0, e_w1, e_cs, e_wr, e_inr, e_sel_w, e_sel_r;
  int            e_g;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wd;
  bit            e_rdv0, e_rdv1;
  logic [DW-1:0] e_rd0, e_rd1;

  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  task automatic model_reset();
    ref_last = 1;
    ex_pend  = 1'b0;
  endtask

  task automatic predict();
    bit r0 = m0_read | m0_write;
    bit r1 = m1_read | m1_write;
    e_gv = r0 | r1;
    if (r0 && r1) e_g = (ref_last == 0) ? 1 : 0;
    else          e_g = r1 ? 1 : 0;
    e_w0 = r0 && !(e_gv && e_g == 0);
    e_w1 = r1 && !(e_gv && e_g == 1);
    if (e_g == 1) begin
      e_addr = m1_address; e_be = m1_byteenable; e_wd = m1_writedata;
      e_sel_w = m1_write;  e_sel_r = m1_read;
    end else begin
      e_addr = m0_address; e_be = m0_byteenable; e_wd = m0_writedata;
      e_sel_w = m0_write;  e_sel_r = m0_read;
    end
    e_inr  = int'(e_addr) < DEPTH;
    e_cs   = e_gv && e_inr;
    e_wr   = e_cs && e_sel_w;
    e_rdv0 = ex_pend && ex_owner == 0;
    e_rdv1 = ex_pend && ex_owner == 1;
    e_rd0  = e_rdv0 ? ex_data : '0;
    e_rd1  = e_rdv1 ? ex_data : '0;
  endtask

  task automatic commit();
    ex_pend = 1'b0;
    if (e_gv) begin
      ref_last = e_g;
      if (e_sel_w) begin
        if (e_inr) ref_mem[int'(e_addr)] = merge(ref_rd(e_addr), e_wd, e_be);
      end else if (e_sel_r) begin
        ex_pend  = 1'b1;
        ex_owner = e_g;
        ex_data  = e_inr ? ref_rd(e_addr) : '0;
      end
    end
  endtask

  task automatic set_m0(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    set_m0(0, 0, '0, '0, '0);
    set_m1(0, 0, '0, '0, '0);
  endtask

  task automatic sample();
    predict();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    m0_read = 1'b1; m1_read = 1'b1;
    @(negedge clk);
    checks++; if (ram_clken !== 1'b0) begin errors++; $display("FAIL reset_clken got=%b want=0", ram_clken); end
    checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b want=0", ram_chipselect); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL reset_wait got=%b%b want=11", m0_waitrequest, m1_waitrequest); end
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv got=%b%b want=00", m0_readdatavalid, m1_readdatavalid); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    idle();
    sample();
    checks++; if (ram_clken !== 1'b1) begin errors++; $display("FAIL run_clken got=%b want=1", ram_clken); end
    tick();
  endtask

  task automatic test_single_read();
    logic [31:0] want = ref_rd(16);
    set_m0(1, 0, 15'h0010, '1, '0);
    sample();
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL single_wait0 got=%b want=0", m0_waitrequest); end
    checks++; if (ram_chipselect !== 1'b1 || ram_address !== 15'h0010 || ram_write !== 1'b0) begin errors++; $display("FAIL single_ram got cs=%b a=%h w=%b want cs=1 a=0010 w=0", ram_chipselect, ram_address, ram_write); end
    checks++; if (m1_waitrequest !== 1'b0 || m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL single_m1_idle got wait=%b rdv=%b want 0 0", m1_waitrequest, m1_readdatavalid); end
    tick();
    idle();
    sample();
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== want) begin errors++; $display("FAIL single_data got rdv=%b d=%h want rdv=1 d=%h", m0_readdatavalid, m0_readdata, want); end
    checks++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== '0) begin errors++; $display("FAIL single_m1_data got rdv=%b d=%h want 0 0", m1_readdatavalid, m1_readdata); end
    tick();
  endtask

  task automatic test_alternate();
    logic [AW-1:0] a0, a1, prev_a;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a0 = AW'($urandom_range(0, DEPTH - 1));
      a1 = AW'($urandom_range(0, DEPTH - 1));
      set_m0(1, 0, a0, '1, '0);
      set_m1(1, 0, a1, '1, '0);
      sample();
      checks++; if ({m0_waitrequest, m1_waitrequest} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_grant cyc=%0d got=%b%b", i, m0_waitrequest, m1_waitrequest); end
      checks++; if (ram_address !== ((i % 2 == 0) ? a0 : a1)) begin errors++; $display("FAIL alt_addr cyc=%0d got=%h want=%h", i, ram_address, (i % 2 == 0) ? a0 : a1); end
      if (i > 0) begin
        checks++; if (m0_readdatavalid !== (i % 2 == 1) || m1_readdatavalid !== (i % 2 == 0)) begin errors++; $display("FAIL alt_rdv cyc=%0d got=%b%b", i, m0_readdatavalid, m1_readdatavalid); end
        checks++; if ((m0_readdata | m1_readdata) !== ref_rd(prev_a)) begin errors++; $display("FAIL alt_data cyc=%0d got=%h want=%h", i, m0_readdata | m1_readdata, ref_rd(prev_a)); end
      end
      prev_a = (i % 2 == 0) ? a0 : a1;
      tick();
    end
    idle();
    sample();
    tick();
  endtask

  task automatic test_byteenable();
    logic [31:0] old = ref_rd(256);
    idle();
    set_m1(0, 1, 15'h0100, 4'h3, 32'hDEADBEEF);
    sample();
    checks++; if (m1_waitrequest !== 1'b0 || ram_write !== 1'b1 || ram_byteenable !== 4'h3 || ram_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL be_write got wait=%b w=%b be=%h d=%h", m1_waitrequest, ram_write, ram_byteenable, ram_writedata); end
    tick();
    idle();
    set_m0(1, 0, 15'h0100, '1, '0);
    sample();
    tick();
    idle();
    sample();
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== {old[31:16], 16'hBEEF}) begin errors++; $display("FAIL be_readback got=%h want=%h", m0_readdata, {old[31:16], 16'hBEEF}); end
    tick();
  endtask

  task automatic test_out_of_range();
    int unsigned cnt;
    idle();
    set_m0(1, 0, 15'h5000, '1, '0);
    sample();
    checks++; if (ram_chipselect !== 1'b0 || m0_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_read got cs=%b wait=%b want 0 0", ram_chipselect, m0_waitrequest); end
    tick();
    idle();
    sample();
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin errors++; $display("FAIL oor_data got rdv=%b d=%h want 1 0", m0_readdatavalid, m0_readdata); end
    tick();
    cnt = ram_wr_count;
    set_m1(0, 1, 15'h7FFF, '1, 32'hCAFEF00D);
    sample();
    checks++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0 || m1_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_write got cs=%b w=%b wait=%b want 0 0 0", ram_chipselect, ram_write, m1_waitrequest); end
    tick();
    idle();
    sample();
    tick();
    checks++; if (ram_wr_count !== cnt) begin errors++; $display("FAIL oor_ram_untouched got=%0d want=%0d", ram_wr_count, cnt); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a = AW'($urandom_range(0, DEPTH - 1));
    logic [31:0] old = ref_rd(a);
    logic [31:0] d = $urandom;
    idle();
    set_m0(1, 0, a, '1, '0);
    sample();
    tick();
    idle();
    set_m1(0, 1, a, 4'hF, d);
    sample();
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== old) begin errors++; $display("FAIL b2b_old got=%h want=%h", m0_readdata, old); end
    checks++; if (m1_waitrequest !== 1'b0 || ram_write !== 1'b1) begin errors++; $display("FAIL b2b_write got wait=%b w=%b want 0 1", m1_waitrequest, ram_write); end
    tick();
    idle();
    set_m0(1, 0, a, '1, '0);
    sample();
    tick();
    idle();
    sample();
    checks++; if (m0_readdata !== d) begin errors++; $display("FAIL b2b_new got=%h want=%h", m0_readdata, d); end
    tick();
  endtask

  task automatic test_reset_midflight();
    idle();
    set_m1(1, 0, 15'h0020, '1, '0);
    sample();
    checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_accept got=%b want=0", m1_waitrequest); end
    tick();
    reset_n = 1'b0;
    set_m0(1, 0, 15'h0030, '1, '0);
    set_m1(1, 0, 15'h0040, '1, '0);
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== '0) begin errors++; $display("FAIL rst_no_rdv got rdv=%b d=%h want 0 0", m1_readdatavalid, m1_readdata); end
    checks++; if (ram_clken !== 1'b0) begin errors++; $display("FAIL rst_clken got=%b want=0", ram_clken); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    sample();
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL rst_first_tie got=%b%b want=01", m0_waitrequest, m1_waitrequest); end
    checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_stale_rdv got=%b want=0", m1_readdatavalid); end
    tick();
    idle();
    sample();
    checks++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_after got=%b%b want=10", m0_readdatavalid, m1_readdatavalid); end
    tick();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned p = $urandom_range(0, 9);
    if (p == 0) return AW'($urandom_range(DEPTH, 32767));
    if (p < 5)  return AW'($urandom_range(0, 15));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_m0($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, rand_addr(), 4'($urandom), $urandom);
      set_m1($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, rand_addr(), 4'($urandom), $urandom);
      sample();
      checks++; if (m0_waitrequest !== e_w0 || m1_waitrequest !== e_w1) begin errors++; $display("FAIL rnd_wait cyc=%0d got=%b%b want=%b%b", i, m0_waitrequest, m1_waitrequest, e_w0, e_w1); end
      checks++; if (ram_chipselect !== e_cs || ram_write !== e_wr) begin errors++; $display("FAIL rnd_cs cyc=%0d got cs=%b w=%b want cs=%b w=%b", i, ram_chipselect, ram_write, e_cs, e_wr); end
      if (e_cs) begin
        checks++; if (ram_address !== e_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", i, ram_address, e_addr); end
      end
      if (e_wr) begin
        checks++; if (ram_byteenable !== e_be || ram_writedata !== e_wd) begin errors++; $display("FAIL rnd_wdata cyc=%0d got be=%h d=%h want be=%h d=%h", i, ram_byteenable, ram_writedata, e_be, e_wd); end
      end
      checks++; if (m0_readdatavalid !== e_rdv0 || m0_readdata !== e_rd0) begin errors++; $display("FAIL rnd_m0_ret cyc=%0d got rdv=%b d=%h want rdv=%b d=%h", i, m0_readdatavalid, m0_readdata, e_rdv0, e_rd0); end
      checks++; if (m1_readdatavalid !== e_rdv1 || m1_readdata !== e_rd1) begin errors++; $display("FAIL rnd_m1_ret cyc=%0d got rdv=%b d=%h want rdv=%b d=%h", i, m1_readdatavalid, m1_readdata, e_rdv1, e_rd1); end
      tick();
    end
    idle();
    sample();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_byteenable();
    test_out_of_range();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios2_ram_arbiter.md
NIOS2_RAM_ARBITER -- requirements
Module: nios2_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning word-address width shared with the on-chip RAM.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 20480, meaning number of implemented RAM words.
REQ-004 SHALL have port clk, input, 1, meaning sole clock.
REQ-005 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports m0_address / m1_address, input, ADDR_W, meaning master word address.
REQ-007 SHALL have ports m0_read, m0_write / m1_read, m1_write, input, 1 each, meaning request strobes.
REQ-008 SHALL have ports m0_byteenable / m1_byteenable, input, DATA_W/8, meaning write byte lanes.
REQ-009 SHALL have ports m0_writedata / m1_writedata, input, DATA_W, meaning write data.
REQ-010 SHALL have ports m0_waitrequest / m1_waitrequest, output, 1, meaning request not accepted this cycle.
REQ-011 SHALL have ports m0_readdata / m1_readdata, output, DATA_W, meaning returned read data.
REQ-012 SHALL have ports m0_readdatavalid / m1_readdatavalid, output, 1, meaning readdata valid this cycle.
REQ-013 SHALL have ports ram_address (ADDR_W), ram_byteenable (DATA_W/8), ram_chipselect (1), ram_write (1), ram_writedata (DATA_W), ram_clken (1), all output, meaning single-port RAM slave drive.
REQ-014 SHALL have port ram_readdata, input, DATA_W, meaning RAM q (valid one cycle after address is registered).

Function
REQ-015 SHALL treat a master as requesting when read or write is high; write high takes precedence and the read is ignored.
REQ-016 SHALL grant at most one master per cycle, combinationally from requests and a registered last_grant.
REQ-017 SHALL grant the sole requester when only one requests; on simultaneous requests SHALL grant the master not in last_grant (round-robin).
REQ-018 SHALL update last_grant on the clock edge of every granted cycle; no update when idle.
REQ-019 SHALL assert waitrequest to a requesting master that is not granted and deassert it for the granted master in the same cycle.
REQ-020 SHALL drive waitrequest low for a non-requesting master.
REQ-021 SHALL drive the granted master's address/byteenable/writedata/write onto ram_* and ram_chipselect=1 for in-range addresses (address < DEPTH).
REQ-022 SHALL drive ram_chipselect=0, ram_write=0 when idle or the granted address is >= DEPTH; out-of-range writes are accepted and dropped.
REQ-023 SHALL register, per accepted read, the owning master and an out-of-range flag; readdatavalid for that master SHALL assert exactly one cycle after acceptance.
REQ-024 SHALL return ram_readdata on readdata for in-range reads and all-zeros for out-of-range reads.
REQ-025 SHALL hold readdata at zero for a master whenever its readdatavalid is low.
REQ-026 SHALL sustain one accepted transaction per cycle back-to-back with no bubbles, including read followed by write to the same address (read returns old data).
REQ-027 SHALL drive ram_clken=1 whenever reset_n is high.

Reset
REQ-028 SHALL, while reset_n is low, force last_grant=m1 (so m0 wins the first tie), clear all pending read-valid and out-of-range flags, drive ram_clken=0, ram_chipselect=0, waitrequests=1, readdatavalids=0.
REQ-029 SHALL discard a read accepted in the cycle reset asserts; no readdatavalid follows reset release.

Structure
REQ-030 SHALL place master-id encoding (M0, M1) and default ADDR_W/DATA_W/DEPTH constants in shared package nios2_ram_pkg.
REQ-031 SHALL contain one sub-module nios2_rr_arb2 (two-request round-robin grant with registered last_grant); datapath mux and read-return tracking stay in the top.

Verification
REQ-032 SHALL cover: m0 read addr 0x0010 alone -> m0_waitrequest=0, ram_address=0x0010, m0_readdatavalid=1 next cycle with RAM contents, m1 outputs idle.
REQ-033 SHALL cover: m0 and m1 both read continuously after reset -> grants alternate m0,m1,m0,...; each readdatavalid follows its accepted cycle by one.
REQ-034 SHALL cover: m1 write 0xDEADBEEF byteenable 0x3 addr 0x0100, then m0 read 0x0100 -> m0_readdata=0x????BEEF with upper bytes unchanged.
REQ-035 SHALL cover: m0 read addr 0x5000 (=DEPTH) -> ram_chipselect=0, m0_readdatavalid=1 next cycle, m0_readdata=0x00000000; write to 0x7FFF leaves RAM unmodified.
REQ-036 SHALL cover: reset_n pulled low the cycle after m1 read acceptance -> no m1_readdatavalid, ram_clken=0 during reset, first tie after release granted to m0.
